// File: rtl/softmax_argmax.sv
// Streaming argmax over one frame of softmax probabilities, reporting the
// winning class, its value and the margin to the runner-up.
module softmax_argmax #(
    parameter int DATA_WIDTH = 32,
    parameter int N_CLASSES  = 10,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_WIDTH-1:0]  class_idx,
    output logic [DATA_WIDTH-1:0] class_val,
    output logic [DATA_WIDTH-1:0] margin,
    output logic                  frame_err
);

    typedef enum logic {COLLECT, HOLD} state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_CLASSES - 1);
    localparam logic [IDX_WIDTH-1:0] ONE      = IDX_WIDTH'(1);

    state_t                state;
    state_t                state_nxt;
    logic [IDX_WIDTH-1:0]  cnt;
    logic [IDX_WIDTH-1:0]  idx_q;
    logic [IDX_WIDTH-1:0]  idx_nxt;
    logic [DATA_WIDTH-1:0] max_q;
    logic [DATA_WIDTH-1:0] max_nxt;
    logic [DATA_WIDTH-1:0] second_q;
    logic [DATA_WIDTH-1:0] second_nxt;
    logic                  accept;
    logic                  at_last_idx;
    logic                  frame_end;

    assign accept      = in_valid && in_ready;
    assign at_last_idx = (cnt == LAST_IDX);
    assign frame_end   = accept && (at_last_idx || in_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (frame_end) state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_comb begin
        in_ready  = (state == COLLECT);
        out_valid = (state == HOLD);
    end

    // Strict compare keeps the lowest index on ties, while an equal value
    // still lifts the runner-up so duplicate maxima yield a zero margin.
    always_comb begin
        max_nxt    = max_q;
        second_nxt = second_q;
        idx_nxt    = idx_q;
        if (cnt == '0) begin
            max_nxt    = in_data;
            second_nxt = '0;
            idx_nxt    = '0;
        end else if (in_data > max_q) begin
            second_nxt = max_q;
            max_nxt    = in_data;
            idx_nxt    = cnt;
        end else if (in_data > second_q) begin
            second_nxt = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            max_q    <= '0;
            second_q <= '0;
            idx_q    <= '0;
        end else if (accept) begin
            cnt      <= frame_end ? '0 : cnt + ONE;
            max_q    <= max_nxt;
            second_q <= second_nxt;
            idx_q    <= idx_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            class_idx <= '0;
            class_val <= '0;
            margin    <= '0;
            frame_err <= 1'b0;
        end else if (frame_end) begin
            class_idx <= idx_nxt;
            class_val <= max_nxt;
            margin    <= max_nxt - second_nxt;
            frame_err <= (in_last && !at_last_idx) || (at_last_idx && !in_last);
        end
    end

endmodule

// File: tb/tb_softmax_argmax.sv
// Self-checking bench for softmax_argmax: directed vector table, stall,
// reset and randomized frames checked against a top-2 reference model.
module tb_softmax_argmax;

    localparam int DW = 32;
    localparam int NC = 10;
    localparam int IW = 4;

    typedef logic [NC-1:0][DW-1:0] frame_t;

    typedef struct {
        frame_t      vals;
        int          len;
        bit          lastflag;
        logic [3:0]  eidx;
        logic [31:0] eval;
        logic [31:0] emarg;
        bit          eerr;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] class_idx;
    logic [DW-1:0] class_val;
    logic [DW-1:0] margin;
    logic          frame_err;

    int checks = 0;
    int errors = 0;

    softmax_argmax #(.DATA_WIDTH(DW), .N_CLASSES(NC), .IDX_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .class_idx(class_idx), .class_val(class_val), .margin(margin), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic frame_t packVals(input int a [10]);
        frame_t f;
        for (int i = 0; i < NC; i++) f[i] = 32'(a[i]);
        return f;
    endfunction

    // Winner is the lowest-indexed maximum; runner-up is the largest of all other beats.
    function automatic void modelFrame(input frame_t v, input int len, input bit lastflag,
                                       output logic [3:0] eidx, output logic [31:0] eval,
                                       output logic [31:0] emarg, output bit eerr);
        int          bi;
        logic [31:0] sec;
        bi  = 0;
        sec = 0;
        for (int i = 0; i < len; i++) if (v[i] > v[bi]) bi = i;
        for (int i = 0; i < len; i++) if (i != bi && v[i] > sec) sec = v[i];
        eidx  = 4'(bi);
        eval  = v[bi];
        emarg = v[bi] - sec;
        eerr  = !lastflag || (len < NC);
    endfunction

    task automatic checkReset();
        checkOutput("rst_in_ready", 32'(in_ready), 1);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_class_idx", 32'(class_idx), 0);
        checkOutput("rst_class_val", class_val, 0);
        checkOutput("rst_margin", margin, 0);
        checkOutput("rst_frame_err", 32'(frame_err), 0);
    endtask

    task automatic sendBeat(input logic [31:0] d, input bit last, input int gapPct, output bit ok);
        int w;
        for (int g = 0; g < 3 && $urandom_range(0, 99) < gapPct; g++) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        ok = in_ready;
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL beat_timeout: in_ready stayed %0b, expected 1", in_ready);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic applyStimulus(input frame_t v, input int len, input bit lastflag, input int gapPct,
                                 input bit earlyReady, input int holdCycles,
                                 input logic [3:0] eidx, input logic [31:0] eval,
                                 input logic [31:0] emarg, input bit eerr);
        bit ok;
        for (int i = 0; i < len; i++) begin
            if (earlyReady && i == len - 1) out_ready = 1'b1;
            sendBeat(v[i], lastflag && (i == len - 1), gapPct, ok);
            if (!ok) return;
        end
        checkOutput("out_valid_rise", 32'(out_valid), 1);
        checkOutput("in_ready_hold", 32'(in_ready), 0);
        checkOutput("class_idx", 32'(class_idx), 32'(eidx));
        checkOutput("class_val", class_val, eval);
        checkOutput("margin", margin, emarg);
        checkOutput("frame_err", 32'(frame_err), 32'(eerr));
        if (earlyReady) begin
            @(negedge clk);
            out_ready = 1'b0;
            checkOutput("hold_one_cycle", 32'(out_valid), 0);
        end else begin
            for (int h = 0; h < holdCycles; h++) begin
                in_valid = 1'b1;
                in_data  = $urandom;
                in_last  = 1'($urandom);
                @(negedge clk);
                checkOutput("stall_in_ready", 32'(in_ready), 0);
                checkOutput("stall_out_valid", 32'(out_valid), 1);
                checkOutput("stall_class_idx", 32'(class_idx), 32'(eidx));
                checkOutput("stall_class_val", class_val, eval);
                checkOutput("stall_margin", margin, emarg);
            end
            in_valid  = 1'b0;
            in_last   = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            checkOutput("release_out_valid", 32'(out_valid), 0);
            checkOutput("release_in_ready", 32'(in_ready), 1);
        end
    endtask

    task automatic randomFrame(output frame_t v, output int len, output bit lastflag);
        int mode;
        mode = $urandom_range(0, 2);
        for (int i = 0; i < NC; i++) begin
            case (mode)
                0:       v[i] = 32'($urandom_range(0, 7));
                1:       v[i] = $urandom;
                default: v[i] = 32'($urandom_range(0, 1000));
            endcase
        end
        lastflag = ($urandom_range(0, 9) < 7);
        len      = lastflag ? $urandom_range(1, NC) : NC;
    endtask

    vec_t tbl [6];

    initial begin
        frame_t      v;
        int          len;
        bit          lf;
        bit          ok;
        logic [3:0]  eidx;
        logic [31:0] eval;
        logic [31:0] emarg;
        bit          eerr;

        tbl[0] = '{packVals('{5, 9, 3, 0, 12, 7, 1, 2, 4, 8}), 10, 1'b1, 4'd4, 32'd12, 32'd3, 1'b0};
        tbl[1] = '{packVals('{1, 20, 3, 20, 0, 0, 0, 0, 0, 0}), 10, 1'b1, 4'd1, 32'd20, 32'd0, 1'b0};
        tbl[2] = '{packVals('{2, 6, 4, 1, 99, 99, 99, 99, 99, 99}), 4, 1'b1, 4'd1, 32'd6, 32'd2, 1'b1};
        tbl[3] = '{packVals('{0, 4096, 8192, 12288, 16384, 20480, 24576, 28672, 32768, 1073741824}),
                   10, 1'b0, 4'd9, 32'h4000_0000, 32'h3FFF_8000, 1'b1};
        tbl[4] = '{packVals('{7, 0, 0, 0, 0, 0, 0, 0, 0, 0}), 1, 1'b1, 4'd0, 32'd7, 32'd7, 1'b1};
        tbl[5] = '{packVals('{5, 5, 5, 5, 5, 5, 5, 5, 5, 5}), 10, 1'b1, 4'd0, 32'd5, 32'd0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkReset();
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 6; t++) begin
            applyStimulus(tbl[t].vals, tbl[t].len, tbl[t].lastflag, (t % 2) * 30, 1'b0, t % 3,
                          tbl[t].eidx, tbl[t].eval, tbl[t].emarg, tbl[t].eerr);
        end

        randomFrame(v, len, lf);
        modelFrame(v, len, lf, eidx, eval, emarg, eerr);
        applyStimulus(v, len, lf, 0, 1'b0, 20, eidx, eval, emarg, eerr);
        randomFrame(v, len, lf);
        modelFrame(v, len, lf, eidx, eval, emarg, eerr);
        applyStimulus(v, len, lf, 0, 1'b1, 0, eidx, eval, emarg, eerr);

        // Reset mid-frame after six beats delivered with gaps.
        for (int i = 0; i < 6; i++) sendBeat(32'($urandom_range(1, 500)), 1'b0, 40, ok);
        #2 rst_n = 1'b0;
        #1 checkReset();
        @(negedge clk);
        rst_n = 1'b1;
        randomFrame(v, len, lf);
        modelFrame(v, len, lf, eidx, eval, emarg, eerr);
        applyStimulus(v, len, lf, 20, 1'b0, 1, eidx, eval, emarg, eerr);

        // Reset while a result is pending in HOLD.
        for (int i = 0; i < NC; i++) sendBeat(32'(i + 100), i == NC - 1, 0, ok);
        checkOutput("pre_reset_valid", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1 checkReset();
        @(negedge clk);
        rst_n = 1'b1;

        for (int f = 0; f < 1000; f++) begin
            randomFrame(v, len, lf);
            modelFrame(v, len, lf, eidx, eval, emarg, eerr);
            applyStimulus(v, len, lf, 25, ($urandom_range(0, 3) == 0), $urandom_range(0, 3),
                          eidx, eval, emarg, eerr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
